// File: rtl/stpw_uart_reporter.sv
// Stopwatch time reporter: snapshots hh:mm:ss.cc on start and streams it as ASCII over a valid/ready byte port.
// Optional hour field enabled by defining RPT_HOUR_FIELD_EN (default build sends "MM:SS.CC\r\n").
module stpw_uart_reporter #(
   parameter logic [7:0] FIELD_SEP = 8'h3A,
   parameter logic [7:0] FRAC_SEP  = 8'h2E
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] msec,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hour,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

`ifdef RPT_HOUR_FIELD_EN
   localparam logic [3:0] LAST_IDX = 4'd12;
`else
   localparam logic [3:0] LAST_IDX = 4'd9;
`endif

   logic [1:0] state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_valid_q, tx_valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       snap_en_s;
   logic [6:0] msec_q;
   logic [5:0] sec_q;
   logic [5:0] min_q;
   logic [15:0] cs_pair_s;
   logic [15:0] sec_pair_s;
   logic [15:0] min_pair_s;
   logic [3:0]  sel_idx_s;
   logic [7:0]  sel_byte_s;
`ifdef RPT_HOUR_FIELD_EN
   logic [4:0]  hour_q;
   logic [15:0] hour_pair_s;
`else
   logic        unused_hour_s;
   assign unused_hour_s = ^hour;
`endif

   // Two ASCII digits {tens, units}; values above 99 saturate to "99".
   function automatic logic [15:0] ascii_pair(input logic [6:0] v);
      logic [6:0] sat;
      logic [6:0] tens;
      logic [6:0] units;
      sat   = (v > 7'd99) ? 7'd99 : v;
      tens  = sat / 7'd10;
      units = sat % 7'd10;
      return {8'h30 + {1'b0, tens}, 8'h30 + {1'b0, units}};
   endfunction

   // Digit conversion of the frozen snapshot fields.
   always_comb begin
      cs_pair_s  = ascii_pair(msec_q);
      sec_pair_s = ascii_pair({1'b0, sec_q});
      min_pair_s = ascii_pair({1'b0, min_q});
`ifdef RPT_HOUR_FIELD_EN
      hour_pair_s = ascii_pair({2'b00, hour_q});
`endif
   end

   // Byte selector: LOAD primes byte 0, SEND prefetches the byte after the one being accepted.
   always_comb begin
      sel_idx_s  = (state_q == ST_SEND) ? (idx_q + 4'd1) : 4'd0;
      sel_byte_s = 8'h00;
      case (sel_idx_s)
`ifdef RPT_HOUR_FIELD_EN
         4'd0:    sel_byte_s = hour_pair_s[15:8];
         4'd1:    sel_byte_s = hour_pair_s[7:0];
         4'd2:    sel_byte_s = FIELD_SEP;
         4'd3:    sel_byte_s = min_pair_s[15:8];
         4'd4:    sel_byte_s = min_pair_s[7:0];
         4'd5:    sel_byte_s = FIELD_SEP;
         4'd6:    sel_byte_s = sec_pair_s[15:8];
         4'd7:    sel_byte_s = sec_pair_s[7:0];
         4'd8:    sel_byte_s = FRAC_SEP;
         4'd9:    sel_byte_s = cs_pair_s[15:8];
         4'd10:   sel_byte_s = cs_pair_s[7:0];
         4'd11:   sel_byte_s = 8'h0D;
         4'd12:   sel_byte_s = 8'h0A;
`else
         4'd0:    sel_byte_s = min_pair_s[15:8];
         4'd1:    sel_byte_s = min_pair_s[7:0];
         4'd2:    sel_byte_s = FIELD_SEP;
         4'd3:    sel_byte_s = sec_pair_s[15:8];
         4'd4:    sel_byte_s = sec_pair_s[7:0];
         4'd5:    sel_byte_s = FRAC_SEP;
         4'd6:    sel_byte_s = cs_pair_s[15:8];
         4'd7:    sel_byte_s = cs_pair_s[7:0];
         4'd8:    sel_byte_s = 8'h0D;
         4'd9:    sel_byte_s = 8'h0A;
`endif
         default: sel_byte_s = 8'h00;
      endcase
   end

   // Frame FSM; outputs are registered from next-state values so they line up with the state.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      done_d     = 1'b0;
      snap_en_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_LOAD;
               idx_d     = 4'd0;
               snap_en_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_d    = ST_SEND;
            idx_d      = 4'd0;
            tx_valid_d = 1'b1;
            tx_data_d  = sel_byte_s;
         end
         ST_SEND: begin
            if (tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d    = ST_DONE;
                  tx_valid_d = 1'b0;
                  tx_data_d  = 8'h00;
                  done_d     = 1'b1;
               end else begin
                  idx_d     = idx_q + 4'd1;
                  tx_data_d = sel_byte_s;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            idx_d   = 4'd0;
         end
         default: begin
            state_d    = ST_IDLE;
            idx_d      = 4'd0;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, output and snapshot registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= 4'd0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         msec_q     <= 7'd0;
         sec_q      <= 6'd0;
         min_q      <= 6'd0;
`ifdef RPT_HOUR_FIELD_EN
         hour_q     <= 5'd0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         if (snap_en_s) begin
            msec_q <= msec;
            sec_q  <= sec;
            min_q  <= min;
`ifdef RPT_HOUR_FIELD_EN
            hour_q <= hour;
`endif
         end
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_stpw_uart_reporter.sv
// Scoreboard bench for stpw_uart_reporter; follows RPT_HOUR_FIELD_EN for the expected frame layout.
module tb_stpw_uart_reporter;

`ifdef RPT_HOUR_FIELD_EN
   localparam int FRAME_LEN = 13;
`else
   localparam int FRAME_LEN = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic       hold_pending = 1'b0;
   logic [7:0] hold_val = 8'h00;

   stpw_uart_reporter dut (
      .clk(clk), .rst(rst), .start(start), .msec(msec), .sec(sec), .min(min), .hour(hour),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic void push_pair(input int v);
      int t;
      t = (v > 99) ? 99 : v;
      exp_q.push_back(8'(48 + t / 10));
      exp_q.push_back(8'(48 + t % 10));
   endfunction

   function automatic void push_frame(input int h, input int m, input int s, input int c);
`ifdef RPT_HOUR_FIELD_EN
      push_pair(h);
      exp_q.push_back(8'h3A);
`else
      if (h < 0) exp_q.push_back(8'hFF);
`endif
      push_pair(m);
      exp_q.push_back(8'h3A);
      push_pair(s);
      exp_q.push_back(8'h2E);
      push_pair(c);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   // Scoreboard monitor: accepted bytes, hold-under-backpressure, idle data.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            if (hold_pending && tx_valid) begin
               checks++;
               if (tx_data !== hold_val) begin
                  failures++;
                  $display("FAIL hold_stable got=%h want=%h", tx_data, hold_val);
               end
            end
            if (!tx_valid) begin
               checks++;
               if (tx_data !== 8'h00) begin
                  failures++;
                  $display("FAIL idle_data got=%h want=00", tx_data);
               end
            end else if (tx_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL extra_byte got=%h want=none", tx_data);
               end else begin
                  e = exp_q.pop_front();
                  if (tx_data !== e) begin
                     failures++;
                     $display("FAIL frame_byte got=%h want=%h", tx_data, e);
                  end
               end
            end
            hold_pending = tx_valid && !tx_ready;
            hold_val     = tx_data;
         end else begin
            hold_pending = 1'b0;
         end
      end
   end

   task automatic pulse_start(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                              input logic [6:0] c);
      @(posedge clk);
      #1;
      hour = h; min = m; sec = s; msec = c;
      tx_ready = 1'b1;
      start = 1'b1;
      push_frame(int'(h), int'(m), int'(s), int'(c));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input int mode, input bit disturb, input bit stop_at_done,
                            output int first_valid, output int done_cyc, output int ndone,
                            output logic busy_after);
      first_valid = -1; done_cyc = -1; ndone = 0; busy_after = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         tx_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
         if (disturb && i == 3) begin
            hour = 5'd23; min = 6'd59; sec = 6'd59; msec = 7'd99; start = 1'b1;
         end else if (disturb && i == 4) begin
            start = 1'b0;
         end
         @(negedge clk);
         if (tx_valid && first_valid < 0) first_valid = i;
         if (done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = i;
         end
         if (done_cyc >= 0 && i == done_cyc + 1) busy_after = busy;
         if (done_cyc >= 0 && (stop_at_done || i == done_cyc + 3)) break;
      end
      start = 1'b0;
      tx_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; tx_ready = 1'b1;
      msec = 7'd0; sec = 6'd0; min = 6'd0; hour = 5'd0;
      #3;
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_basic();
      int fv, dc, nd;
      logic ba;
      pulse_start(5'd5, 6'd7, 6'd42, 7'd9);
      @(negedge clk);
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL load_tx_valid got=%b want=0", tx_valid); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL load_busy got=%b want=1", busy); end
      run_frame(0, 1'b0, 1'b0, fv, dc, nd, ba);
      checks++; if (fv != 0) begin failures++; $display("FAIL basic_valid_latency got=%0d want=0", fv); end
      checks++; if (dc != FRAME_LEN) begin failures++; $display("FAIL basic_done_cycle got=%0d want=%0d", dc, FRAME_LEN); end
      checks++; if (nd != 1) begin failures++; $display("FAIL basic_done_count got=%0d want=1", nd); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b want=0", ba); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_bytes_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      int fv, dc, nd;
      logic ba;
      pulse_start(5'd5, 6'd7, 6'd42, 7'd9);
      run_frame(1, 1'b0, 1'b0, fv, dc, nd, ba);
      checks++; if (nd != 1) begin failures++; $display("FAIL bp_done_count got=%0d want=1", nd); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_bytes_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_snapshot();
      int fv, dc, nd;
      logic ba;
      pulse_start(5'd1, 6'd2, 6'd3, 7'd4);
      run_frame(1, 1'b1, 1'b0, fv, dc, nd, ba);
      checks++; if (nd != 1) begin failures++; $display("FAIL snap_done_count got=%0d want=1", nd); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL snap_busy_after got=%b want=0", ba); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL snap_bytes_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_saturation();
      int fv, dc, nd;
      logic ba;
      pulse_start(5'd31, 6'd59, 6'd0, 7'd120);
      run_frame(0, 1'b0, 1'b0, fv, dc, nd, ba);
      checks++; if (nd != 1) begin failures++; $display("FAIL sat_done_count got=%0d want=1", nd); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sat_bytes_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_zero();
      int fv, dc, nd;
      logic ba;
      pulse_start(5'd17, 6'd0, 6'd0, 7'd0);
      run_frame(0, 1'b0, 1'b0, fv, dc, nd, ba);
      checks++; if (dc != FRAME_LEN) begin failures++; $display("FAIL zero_done_cycle got=%0d want=%0d", dc, FRAME_LEN); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL zero_bytes_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int fv, dc, nd;
      logic ba;
      pulse_start(5'd12, 6'd34, 6'd56, 7'd78);
      run_frame(0, 1'b0, 1'b1, fv, dc, nd, ba);
      pulse_start(5'd1, 6'd1, 6'd1, 7'd1);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b want=1", busy); end
      run_frame(0, 1'b0, 1'b0, fv, dc, nd, ba);
      checks++; if (fv != 0) begin failures++; $display("FAIL b2b_valid_latency got=%0d want=0", fv); end
      checks++; if (nd != 1) begin failures++; $display("FAIL b2b_done_count got=%0d want=1", nd); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_bytes_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_reset_midframe();
      int fv, dc, nd, k;
      logic ba;
      k = 0;
      pulse_start(5'd9, 6'd8, 6'd7, 7'd6);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx_valid && tx_ready) k++;
         if (k == 4) break;
      end
      checks++; if (k != 4) begin failures++; $display("FAIL rstmid_bytes_seen got=%0d want=4", k); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_tx_valid got=%b want=0", tx_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx_data got=%h want=00", tx_data); end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL rstmid_wait_idle got=%b%b want=00", tx_valid, busy);
      end
      pulse_start(5'd9, 6'd8, 6'd7, 7'd6);
      run_frame(0, 1'b0, 1'b0, fv, dc, nd, ba);
      checks++; if (dc != FRAME_LEN) begin failures++; $display("FAIL rstmid_done_cycle got=%0d want=%0d", dc, FRAME_LEN); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rstmid_bytes_left got=%0d want=0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_snapshot();
      test_saturation();
      test_zero();
      test_back_to_back();
      test_reset_midframe();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
